inst_fetch_queue: RTL and testbench

Fetch-side stage between the PC/instruction-memory interface and the Decode stage. Owns the fetch PC, issues word-aligned read requests to instruction memory over a valid/ready handshake, and buffers in-order responses in a DEPTH-entry FIFO. Presents {instruction, pc} pairs to Decode with a valid/ready handshake. Handles control-flow redirects by flushing buffered entries and discarding in-flight responses.

---
 rtl/inst_fetch_queue.sv | 163 ++++++++++++++++
 tb/tb_inst_fetch_queue.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// Fetch stage: owns the fetch PC, issues credit-limited instruction reads, and buffers in-order
// responses as {instruction, pc} pairs for Decode. Redirects flush the buffer and drop in-flight data.
module inst_fetch_queue #(
    parameter int unsigned       X_LEN    = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [X_LEN-1:0]  RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             first_inst_add_en,
    input  logic [X_LEN-1:0] first_inst_add,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [X_LEN-1:0] imem_req_addr,
    input  logic             imem_rsp_valid,
    input  logic [X_LEN-1:0] imem_rsp_data,
    input  logic             redirect_valid,
    input  logic [X_LEN-1:0] redirect_pc,
    output logic             dec_valid,
    input  logic             dec_ready,
    output logic [X_LEN-1:0] dec_instruction,
    output logic [X_LEN-1:0] dec_pc,
    output logic [X_LEN-1:0] pc
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef logic [CntW-1:0] cnt_t;
    typedef logic [PtrW-1:0] ptr_t;

    localparam cnt_t             DepthCnt  = cnt_t'(DEPTH);
    localparam logic [X_LEN-1:0] AlignMask = ~(X_LEN'(3));

    // Instruction/PC buffer and the parallel tag FIFO of accepted request addresses
    logic [X_LEN-1:0] instr_q  [DEPTH];
    logic [X_LEN-1:0] pc_buf_q [DEPTH];
    logic [X_LEN-1:0] tag_q    [DEPTH];

    logic [X_LEN-1:0] pc_q, pc_d;
    ptr_t             wr_ptr_q, wr_ptr_d;
    ptr_t             rd_ptr_q, rd_ptr_d;
    ptr_t             tag_wr_q, tag_wr_d;
    ptr_t             tag_rd_q, tag_rd_d;
    cnt_t             count_q, count_d;
    cnt_t             outstanding_q, outstanding_d;
    cnt_t             drop_q, drop_d;

    logic [CntW:0]    used;
    logic             credit_ok;
    logic             req_fire;
    logic             rsp_keep;
    logic             rsp_drop;
    logic             pop;
    logic [X_LEN-1:0] boot_pc;
    logic [X_LEN-1:0] redirect_target;

    assign boot_pc         = first_inst_add_en ? (first_inst_add & AlignMask) : RESET_PC;
    assign redirect_target = redirect_pc & AlignMask;

    // Every in-flight request, including those already marked for dropping, holds a slot
    assign used      = {1'b0, count_q} + {1'b0, outstanding_q};
    assign credit_ok = used < {1'b0, DepthCnt};

    assign imem_req_valid = !rst && !redirect_valid && credit_ok;
    assign imem_req_addr  = pc_q;
    assign pc             = pc_q;

    assign req_fire = imem_req_valid && imem_req_ready;
    assign rsp_drop = imem_rsp_valid && (drop_q != '0);
    assign rsp_keep = imem_rsp_valid && (drop_q == '0);

    assign dec_valid       = (count_q != '0);
    assign pop             = dec_valid && dec_ready;
    assign dec_instruction = dec_valid ? instr_q[rd_ptr_q] : '0;
    assign dec_pc          = dec_valid ? pc_buf_q[rd_ptr_q] : '0;

    always_comb begin
        pc_d          = pc_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        tag_wr_d      = tag_wr_q;
        tag_rd_d      = tag_rd_q;
        count_d       = count_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;

        unique case ({req_fire, imem_rsp_valid})
            2'b10:   outstanding_d = outstanding_q + cnt_t'(1);
            2'b01:   outstanding_d = outstanding_q - cnt_t'(1);
            default: outstanding_d = outstanding_q;
        endcase

        if (redirect_valid) begin
            pc_d     = redirect_target;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            tag_wr_d = '0;
            tag_rd_d = '0;
            count_d  = '0;
            // Whatever is still in flight after this edge belongs to the old stream
            drop_d   = outstanding_d;
        end else begin
            if (req_fire) begin
                pc_d     = pc_q + X_LEN'(4);
                tag_wr_d = tag_wr_q + ptr_t'(1);
            end
            if (rsp_keep) begin
                wr_ptr_d = wr_ptr_q + ptr_t'(1);
                tag_rd_d = tag_rd_q + ptr_t'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + ptr_t'(1);
            end
            unique case ({rsp_keep, pop})
                2'b10:   count_d = count_q + cnt_t'(1);
                2'b01:   count_d = count_q - cnt_t'(1);
                default: count_d = count_q;
            endcase
            if (rsp_drop) begin
                drop_d = drop_q - cnt_t'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= boot_pc;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            tag_wr_q      <= '0;
            tag_rd_q      <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            pc_q          <= pc_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            tag_wr_q      <= tag_wr_d;
            tag_rd_q      <= tag_rd_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by count and pointers alone
    always_ff @(posedge clk) begin
        if (!rst && rsp_keep) begin
            instr_q[wr_ptr_q]  <= imem_rsp_data;
            pc_buf_q[wr_ptr_q] <= tag_q[tag_rd_q];
        end
        if (req_fire) begin
            tag_q[tag_wr_q] <= pc_q;
        end
    end

    rsp_needs_outstanding: assert property (
        @(posedge clk) disable iff (rst) imem_rsp_valid |-> (outstanding_q != '0)
    );

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomised bench for inst_fetch_queue: an in-order memory model plus an epoch-tagged
// queue model of the fetch stream predicts every handshake and every Decode output.
module tb_inst_fetch_queue;

    localparam int unsigned XL    = 32;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] KEY   = 32'hA5A5_A5A5;

    logic        clk;
    logic        rst;
    logic        first_inst_add_en;
    logic [31:0] first_inst_add;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instruction;
    logic [31:0] dec_pc;
    logic [31:0] pc;

    inst_fetch_queue #(
        .X_LEN    (XL),
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .first_inst_add_en (first_inst_add_en),
        .first_inst_add    (first_inst_add),
        .imem_req_valid    (imem_req_valid),
        .imem_req_ready    (imem_req_ready),
        .imem_req_addr     (imem_req_addr),
        .imem_rsp_valid    (imem_rsp_valid),
        .imem_rsp_data     (imem_rsp_data),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .dec_valid         (dec_valid),
        .dec_ready         (dec_ready),
        .dec_instruction   (dec_instruction),
        .dec_pc            (dec_pc),
        .pc                (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
        int unsigned epoch;
    } mem_req_t;

    mem_req_t    memq[$];   // accepted requests awaiting their response
    logic [31:0] modq[$];   // addresses buffered for Decode, oldest first

    int          checks;
    int          failures;
    int unsigned cycle;
    int unsigned epoch;
    logic [31:0] exp_req;

    // Stimulus knobs
    int          ready_mode;   // 0 always, 1 toggle, 2 random
    int          dec_mode;     // 0 stall, 1 always, 2 random
    int unsigned lat;
    bit          lat_rand;
    bit          rand_redirect;
    bit          force_redir;
    logic [31:0] force_pc;

    // Observations
    int          accepts;
    int          pops;
    logic [31:0] last_acc;
    bit          first_seen;
    logic [31:0] first_pop_pc;
    logic [31:0] prev_pop_pc;
    bit          saw_wrap;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic do_reset(input bit en, input logic [31:0] addr);
        @(negedge clk);
        rst               = 1'b1;
        first_inst_add_en = en;
        first_inst_add    = addr;
        // Reset must win over a same-cycle redirect and response
        redirect_valid    = 1'b1;
        redirect_pc       = 32'h0000_0F00;
        imem_rsp_valid    = 1'b1;
        imem_rsp_data     = $urandom;
        imem_req_ready    = 1'b1;
        dec_ready         = 1'b1;
        #1;
        check("req_valid_in_reset", {31'd0, imem_req_valid}, 32'd0);
        @(posedge clk);
        memq.delete();
        modq.delete();
        epoch++;
        exp_req  = en ? {addr[31:2], 2'b00} : 32'h0000_0000;
        cycle    = 0;
        accepts  = 0;
        pops     = 0;
        saw_wrap = 1'b0;
        first_seen  = 1'b0;
        prev_pop_pc = 32'h1;
        #1;
        check("rst_dec_valid", {31'd0, dec_valid}, 32'd0);
        check("rst_dec_pc", dec_pc, 32'd0);
        check("rst_dec_instr", dec_instruction, 32'd0);
        check("rst_pc", pc, exp_req);
    endtask

    task automatic step();
        bit       rsp_v;
        bit       acc;
        bit       pp;
        bit       exp_rv;
        mem_req_t e;
        @(negedge clk);
        rst = 1'b0;
        unique case (ready_mode)
            0:       imem_req_ready = 1'b1;
            1:       imem_req_ready = cycle[0];
            default: imem_req_ready = 1'($urandom_range(0, 1));
        endcase
        unique case (dec_mode)
            0:       dec_ready = 1'b0;
            1:       dec_ready = 1'b1;
            default: dec_ready = 1'($urandom_range(0, 1));
        endcase
        redirect_valid = force_redir || (rand_redirect && ($urandom_range(0, 31) == 0));
        redirect_pc    = force_redir ? force_pc : $urandom;
        rsp_v          = (memq.size() > 0) && (memq[0].due <= cycle);
        imem_rsp_valid = rsp_v;
        imem_rsp_data  = rsp_v ? (memq[0].addr ^ KEY) : $urandom;
        #1;
        exp_rv = !redirect_valid && ((memq.size() + modq.size()) < DEPTH);
        check("req_valid", {31'd0, imem_req_valid}, {31'd0, exp_rv});
        check("pc", pc, exp_req);
        check("req_addr", imem_req_addr, exp_req);
        check("dec_valid", {31'd0, dec_valid}, {31'd0, modq.size() != 0});
        if (modq.size() != 0) begin
            check("dec_pc", dec_pc, modq[0]);
            check("dec_instr", dec_instruction, modq[0] ^ KEY);
        end
        acc = imem_req_valid && imem_req_ready;
        pp  = dec_valid && dec_ready;
        @(posedge clk);
        if (pp && modq.size() != 0) begin
            if (!first_seen) begin
                first_seen   = 1'b1;
                first_pop_pc = modq[0];
            end
            if (prev_pop_pc == 32'hFFFF_FFFC && modq[0] == 32'h0) saw_wrap = 1'b1;
            prev_pop_pc = modq[0];
            pops++;
            void'(modq.pop_front());
        end
        if (rsp_v) begin
            e = memq.pop_front();
            if (e.epoch == epoch) modq.push_back(e.addr);
        end
        if (acc) begin
            e.addr  = exp_req;
            e.due   = cycle + (lat_rand ? $urandom_range(1, 4) : lat);
            e.epoch = epoch;
            memq.push_back(e);
            last_acc = exp_req;
            exp_req  = exp_req + 32'd4;
            accepts++;
        end
        if (redirect_valid) begin
            modq.delete();
            epoch++;
            exp_req = {redirect_pc[31:2], 2'b00};
        end
        cycle++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        checks = 0; failures = 0; cycle = 0; epoch = 0; exp_req = '0;
        rst = 1'b1; first_inst_add_en = 1'b0; first_inst_add = '0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; dec_ready = 1'b0;
        ready_mode = 0; dec_mode = 1; lat = 1; lat_rand = 1'b0;
        rand_redirect = 1'b0; force_redir = 1'b0; force_pc = '0;
        accepts = 0; pops = 0; last_acc = '0; first_seen = 1'b0;
        first_pop_pc = '0; prev_pop_pc = 32'h1; saw_wrap = 1'b0;

        // Boot address from first_inst_add, low bits cleared
        do_reset(1'b1, 32'h0000_1002);
        check("boot_pc", pc, 32'h0000_1000);
        dec_mode = 0;
        run(3);

        // Streaming: one instruction per cycle after a two-cycle fill
        do_reset(1'b0, 32'h0000_1002);
        ready_mode = 0; dec_mode = 1; lat = 1;
        run(20);
        check("stream_pops", pops, 32'd18);

        // Decode stalled: exactly DEPTH requests, then resume at 0x10
        do_reset(1'b0, 32'h0);
        dec_mode = 0;
        run(10);
        check("stall_accepts", accepts, DEPTH);
        dec_mode = 1;
        run(2);
        check("resume_accepts", accepts, DEPTH + 1);
        check("resume_addr", last_acc, 32'h0000_0010);
        run(10);

        // Redirect with two requests in flight
        do_reset(1'b0, 32'h0);
        lat = 3;
        run(2);
        check("inflight_before_redirect", accepts, 32'd2);
        force_redir = 1'b1; force_pc = 32'h0000_0203;
        step();
        force_redir = 1'b0;
        first_seen  = 1'b0;
        run(15);
        check("redirect_first_dec_pc", first_pop_pc, 32'h0000_0200);

        // Toggling ready, 3-cycle latency, random decode stalls and redirects
        do_reset(1'b0, 32'h0);
        ready_mode = 1; dec_mode = 2; lat = 3; rand_redirect = 1'b1;
        run(400);
        ready_mode = 2; lat_rand = 1'b1;
        run(400);
        rand_redirect = 1'b0; lat_rand = 1'b0;

        // PC wrap across the top of the address space
        do_reset(1'b1, 32'hFFFF_FFF4);
        ready_mode = 0; dec_mode = 1; lat = 1;
        run(10);
        check("pc_wrap", {31'd0, saw_wrap}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
